// File: rtl/piso_sipo_defs_pkg.sv
// rtl/piso_sipo_defs_pkg.sv - shared definitions for the PISO transmitter and its paired SIPO receiver
package piso_sipo_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Both ends of the link must agree on bit order.
  localparam bit MSB_FIRST_DEFAULT = 1'b1;

  function automatic int bit_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int div_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - per-bit clock divider; tick marks the last cycle of each serial bit
module bit_tick_gen
  import piso_sipo_defs_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_al_in,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DCW = div_cnt_w(DIV);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

  logic [DCW-1:0] div_cnt;

  // With DIV=1 the counter stays at zero and tick follows en.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/piso_nbit_tx.sv
// rtl/piso_nbit_tx.sv - N-bit parallel-in/serial-out transmitter with valid/ready load and done pulse
module piso_nbit_tx
  import piso_sipo_defs_pkg::*;
#(
  parameter int N         = 16,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic [N-1:0] d_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_frame,
  output logic         busy,
  output logic         done
);

  localparam int BCW = bit_cnt_w(N);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(N - 1);

  state_t         state;
  logic [N-1:0]   shreg;
  logic [N-1:0]   shreg_next;
  logic [BCW-1:0] bit_cnt;
  logic           accept;
  logic           tick;
  logic           first_bit;
  logic           next_bit;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = load_valid && load_ready;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .en          (state == ST_SHIFT),
    .clr         (accept),
    .tick        (tick)
  );

  // The bit on ser_out is always the head of the shift register.
  always_comb begin
    shreg_next = '0;
    first_bit  = 1'b0;
    next_bit   = 1'b0;
    if (MSB_FIRST) begin
      shreg_next = {shreg[N-2:0], 1'b0};
      first_bit  = d_in[N-1];
      next_bit   = shreg_next[N-1];
    end else begin
      shreg_next = {1'b0, shreg[N-1:1]};
      first_bit  = d_in[0];
      next_bit   = shreg_next[0];
    end
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg     <= d_in;
            bit_cnt   <= '0;
            ser_out   <= first_bit;
            ser_frame <= 1'b1;
            state     <= ST_SHIFT;
          end else begin
            ser_out   <= 1'b0;
            ser_frame <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt   <= '0;
              ser_out   <= 1'b0;
              ser_frame <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              shreg   <= shreg_next;
              bit_cnt <= bit_cnt + 1'b1;
              ser_out <= next_bit;
            end
          end
        end
        ST_DONE: begin
          ser_out   <= 1'b0;
          ser_frame <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_nbit_tx.sv
// tb/tb_piso_nbit_tx.sv - scoreboard bench for piso_nbit_tx with MSB-first and LSB-first instances
module tb_piso_nbit_tx;

  localparam int N   = 8;
  localparam int DIV = 2;

  typedef struct packed {
    logic is_done;
    logic b;
    int   cyc;
  } token_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din [2];
  logic [1:0] lv, lr, so, sf, bz, dn;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  token_t     q [2][$];

  piso_nbit_tx #(.N(N), .DIV(DIV), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_al_in(rst_n), .d_in(din[0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .ser_out(so[0]), .ser_frame(sf[0]), .busy(bz[0]), .done(dn[0])
  );

  piso_nbit_tx #(.N(N), .DIV(DIV), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_al_in(rst_n), .d_in(din[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .ser_out(so[1]), .ser_frame(sf[1]), .busy(bz[1]), .done(dn[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle c is the clock period ending at rising edge c.
  task automatic mon(input int i);
    int     now;
    token_t tk;
    now = cyc + 1;
    if (sf[i] || dn[i]) begin
      if (q[i].size() == 0) begin
        chk($sformatf("u%0d_unexpected_output_cycle", i), now, -1);
      end else begin
        tk = q[i].pop_front();
        chk($sformatf("u%0d_done", i), int'(dn[i]), int'(tk.is_done));
        chk($sformatf("u%0d_frame", i), int'(sf[i]), int'(!tk.is_done));
        chk($sformatf("u%0d_cycle", i), now, tk.cyc);
        if (!tk.is_done) chk($sformatf("u%0d_bit", i), int'(so[i]), int'(tk.b));
      end
    end else begin
      if (q[i].size() != 0 && q[i][0].cyc <= now) begin
        chk($sformatf("u%0d_missing_output_cycle", i), now, -1);
        q[i].delete();
      end
      chk($sformatf("u%0d_ser_out_idle", i), int'(so[i]), 0);
    end
    chk($sformatf("u%0d_busy", i), int'(bz[i]), int'(sf[i] | dn[i]));
    chk($sformatf("u%0d_load_ready", i), int'(lr[i]), int'(!bz[i]));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // Call only at posedge+#1 so the accept edge is the posedge after the sampled negedge.
  task automatic do_accept(input int i, input logic [7:0] w, input bit keep, output int t);
    bit     got;
    token_t tk;
    got   = 1'b0;
    din[i] = w;
    lv[i]  = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (lr[i]) got = 1'b1;
    end
    chk($sformatf("u%0d_accept_timeout", i), int'(got), 1);
    @(posedge clk);
    #1;
    t = cyc;
    if (!keep) lv[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < DIV; j++) begin
        tk.is_done = 1'b0;
        tk.b       = (i == 0) ? w[N-1-k] : w[k];
        tk.cyc     = t + 1 + k * DIV + j;
        q[i].push_back(tk);
      end
    end
    tk.is_done = 1'b1;
    tk.b       = 1'b0;
    tk.cyc     = t + N * DIV + 1;
    q[i].push_back(tk);
  endtask

  task automatic drain(input int i);
    for (int n = 0; n < 200 && q[i].size() != 0; n++) @(posedge clk);
    chk($sformatf("u%0d_drain_left", i), q[i].size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    for (int n = 0; n < 200 && (cyc + 1) < target; n++) @(negedge clk);
    chk("wait_cycle_reached", cyc + 1, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t1, t2;
    din[0] = '0;
    din[1] = '0;
    lv     = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("idle_u0", int'({lr[0], bz[0], so[0], sf[0], dn[0]}), 5'b10000);
      chk("idle_u1", int'({lr[1], bz[1], so[1], sf[1], dn[1]}), 5'b10000);
    end
    @(posedge clk);
    #1;

    // single word, MSB first
    do_accept(0, 8'hA5, 1'b0, t);
    drain(0);

    // LSB first
    do_accept(1, 8'h01, 1'b0, t);
    drain(1);

    // back-to-back with d_in changing while busy
    do_accept(0, 8'hFF, 1'b1, t1);
    do_accept(0, 8'h00, 1'b0, t2);
    chk("b2b_accept_gap", t2 - t1, N * DIV + 2);
    drain(0);

    // load offered during bit 3 is ignored, then re-offered
    do_accept(0, 8'hA5, 1'b0, t);
    wait_cycle(t + 1 + 3 * DIV);
    din[0] = 8'h3C;
    lv[0]  = 1'b1;
    repeat (DIV) @(negedge clk);
    lv[0] = 1'b0;
    drain(0);
    do_accept(0, 8'h3C, 1'b0, t);
    drain(0);

    // reset mid-word
    do_accept(0, 8'hA5, 1'b0, t);
    wait_cycle(t + 7);
    #1 rst_n = 1'b0;
    q[0].delete();
    #1;
    chk("reset_midword_outputs", int'({so[0], sf[0], bz[0], dn[0], lr[0]}), 5'b00001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_accept(0, 8'h5A, 1'b0, t);
    drain(0);

    repeat (5) @(posedge clk);
    chk("final_queue_u0", q[0].size(), 0);
    chk("final_queue_u1", q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
